// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and 640x480@60 Hz timing constants for the VGA raster
// generator and its sync/blank delay line.
//   coord_t          : 10-bit raster coordinate (covers 0..1023)
//   H_* / V_*        : visible, porch and sync widths, totals
//   *_SYNC_START/END : first sync pixel/line and first pixel/line after sync
//   SYNC_RST_VEC     : {blank, hs, vs} held in delay stages during reset
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Delay stages come out of reset not visible and not in sync.
  localparam logic [2:0] SYNC_RST_VEC = 3'b011;

endpackage

// File: rtl/vga_sync_delay.sv
// -----------------------------------------------------------------------------
// vga_sync_delay
// PIPE_DELAY-deep shift register carrying {blank, hs, vs} so the sync and
// blank outputs line up with the registered ROM + palette pixel pipeline.
// PIPE_DELAY = 0 gives a straight combinational copy.
// Ports:
//   i_clk, i_rst              : pixel clock, synchronous active-high reset
//   i_blank, i_hs, i_vs       : undelayed raster signals
//   o_blank, o_hs, o_vs       : same signals PIPE_DELAY cycles later
// -----------------------------------------------------------------------------
module vga_sync_delay #(
  parameter int PIPE_DELAY = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_blank,
  input  logic i_hs,
  input  logic i_vs,
  output logic o_blank,
  output logic o_hs,
  output logic o_vs
);
  import vga_pkg::*;

  generate
    if (PIPE_DELAY == 0) begin : g_bypass
      assign {o_blank, o_hs, o_vs} = {i_blank, i_hs, i_vs};
    end else begin : g_pipe
      logic [2:0] r_pipe [PIPE_DELAY];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int k = 0; k < PIPE_DELAY; k++) begin
            r_pipe[k] <= SYNC_RST_VEC;
          end
        end else begin
          r_pipe[0] <= {i_blank, i_hs, i_vs};
          for (int k = 1; k < PIPE_DELAY; k++) begin
            r_pipe[k] <= r_pipe[k-1];
          end
        end
      end

      assign {o_blank, o_hs, o_vs} = r_pipe[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz raster timing generator. Produces pixel coordinates, the
// active-video flag, active-low syncs, pipeline-aligned delayed copies of
// those, line/frame ticks and a completed-frame counter.
// Ports:
//   vga_clk              : pixel clock (25 MHz nominal)
//   reset                : synchronous, active-high
//   DrawX, DrawY         : current horizontal / vertical counter
//   blank                : 1 while the current pixel is visible
//   hs, vs               : active-low syncs for the current pixel
//   blank_d, hs_d, vs_d  : blank/hs/vs delayed PIPE_DELAY cycles
//   line_tick            : pulse on the last pixel of every line
//   frame_tick           : pulse on the last pixel of every frame
//   frame_count          : completed frames, wraps modulo 2^16
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        blank_d,
  output logic        hs_d,
  output logic        vs_d,
  output logic        line_tick,
  output logic        frame_tick,
  output logic [15:0] frame_count
);
  import vga_pkg::*;

  // Decode thresholds sized to the counters so every compare is unsigned 10-bit.
  localparam coord_t HC_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t VC_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t HC_VIS   = coord_t'(H_VISIBLE);
  localparam coord_t VC_VIS   = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t      r_hc, r_vc;
  coord_t      w_hc_nxt, w_vc_nxt;
  logic        r_blank, r_hs, r_vs;
  logic        r_line_tick, r_frame_tick;
  logic [15:0] r_frame_count;

  always_comb begin
    w_hc_nxt = r_hc + 10'd1;
    w_vc_nxt = r_vc;
    if (r_hc == HC_LAST) begin
      w_hc_nxt = '0;
      w_vc_nxt = (r_vc == VC_LAST) ? '0 : r_vc + 10'd1;
    end
  end

  // Decodes are taken from the next-state counters so the registered flags
  // describe the same pixel as DrawX/DrawY in the same cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_blank       <= 1'b1;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_line_tick   <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hc         <= w_hc_nxt;
      r_vc         <= w_vc_nxt;
      r_blank      <= (w_hc_nxt < HC_VIS) && (w_vc_nxt < VC_VIS);
      r_hs         <= !((w_hc_nxt >= HS_START) && (w_hc_nxt < HS_END));
      r_vs         <= !((w_vc_nxt >= VS_START) && (w_vc_nxt < VS_END));
      r_line_tick  <= (w_hc_nxt == HC_LAST);
      r_frame_tick <= (w_hc_nxt == HC_LAST) && (w_vc_nxt == VC_LAST);
      // Bumped on the natural wrap only; reset lands on (0,0) without counting.
      if ((w_hc_nxt == '0) && (w_vc_nxt == '0)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  vga_sync_delay #(
    .PIPE_DELAY (PIPE_DELAY)
  ) u_sync_delay (
    .i_clk   (vga_clk),
    .i_rst   (reset),
    .i_blank (r_blank),
    .i_hs    (r_hs),
    .i_vs    (r_vs),
    .o_blank (blank_d),
    .o_hs    (hs_d),
    .o_vs    (vs_d)
  );

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_tick   = r_line_tick;
  assign frame_tick  = r_frame_tick;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Horizontal timing is the real 800-pixel
// line; the vertical dimensions are scaled down (12 visible, 3 FP, 2 sync,
// 4 BP = 21 lines) so two complete frames plus a mid-vsync reset stay short.
// Vertical checks below use the scaled line numbers that correspond to the
// 480/490/491/524 landmarks of the full-size frame.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HT    = 800;
  localparam int VV    = 12;
  localparam int VFP   = 3;
  localparam int VSY   = 2;
  localparam int VBP   = 4;
  localparam int VT    = VV + VFP + VSY + VBP;   // 21
  localparam int FRAME = HT * VT;                // 16800 cycles
  localparam int VS0   = VV + VFP;               // first vsync line (15)

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [9:0]  DrawX, DrawY;
  logic        blank, hs, vs, blank_d, hs_d, vs_d;
  logic        line_tick, frame_tick;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  vga_timing_gen #(
    .H_VISIBLE  (640),
    .H_FP       (16),
    .H_SYNC     (96),
    .H_BP       (48),
    .V_VISIBLE  (VV),
    .V_FP       (VFP),
    .V_SYNC     (VSY),
    .V_BP       (VBP),
    .PIPE_DELAY (2)
  ) u_dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .blank_d     (blank_d),
    .hs_d        (hs_d),
    .vs_d        (vs_d),
    .line_tick   (line_tick),
    .frame_tick  (frame_tick),
    .frame_count (frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    int mx, my, fc;
    int bad_xy, bad_sync, bad_d, bad_tick;
    int n_lt, n_ft, lt_frame1, last_ft, period, w;
    logic exp_b, exp_h, exp_v, exp_lt, exp_ft;
    logic [2:0] h1, h2;

    // Reset held for several cycles: everything sits at reset values.
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_DrawX",       DrawX,       0);
    chk("rst_DrawY",       DrawY,       0);
    chk("rst_blank",       blank,       1);
    chk("rst_hs",          hs,          1);
    chk("rst_vs",          vs,          1);
    chk("rst_line_tick",   line_tick,   0);
    chk("rst_frame_tick",  frame_tick,  0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_blank_d",     blank_d,     0);
    chk("rst_hs_d",        hs_d,        1);
    chk("rst_vs_d",        vs_d,        1);

    // Release and walk two full frames against a reference raster model.
    reset = 1'b0;
    mx = 0; my = 0; fc = 0;
    h1 = 3'b011; h2 = 3'b011;
    bad_xy = 0; bad_sync = 0; bad_d = 0; bad_tick = 0;
    n_lt = 0; n_ft = 0; lt_frame1 = -1; last_ft = -1; period = 0;

    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      exp_b  = (mx < 640) && (my < VV);
      exp_h  = !((mx >= 656) && (mx < 752));
      exp_v  = !((my >= VS0) && (my < VS0 + VSY));
      exp_lt = (mx == HT - 1);
      exp_ft = exp_lt && (my == VT - 1);

      if ((int'(DrawX) != mx) || (int'(DrawY) != my)) bad_xy++;
      if ({blank, hs, vs} !== {exp_b, exp_h, exp_v}) bad_sync++;
      if ({blank_d, hs_d, vs_d} !== h2) bad_d++;
      if ((line_tick !== exp_lt) || (frame_tick !== exp_ft) ||
          (int'(frame_count) != fc)) bad_tick++;

      if (line_tick === 1'b1) n_lt++;
      if (frame_tick === 1'b1) begin
        n_ft++;
        if (n_ft == 1) lt_frame1 = n_lt;
        if (last_ft >= 0) period = i - last_ft;
        last_ft = i;
      end

      if (my == 10) begin
        case (mx)
          639: chk("blank_x639_y10", blank, 1);
          640: chk("blank_x640_y10", blank, 0);
          655: chk("hs_x655", hs, 1);
          656: chk("hs_x656", hs, 0);
          751: chk("hs_x751", hs, 0);
          752: chk("hs_x752", hs, 1);
          default: ;
        endcase
      end
      if (mx == 0) begin
        case (my)
          VV:           chk("blank_first_invisible_line", blank, 0);
          VS0 - 1:      chk("vs_line_before_sync", vs, 1);
          VS0:          chk("vs_first_sync_line", vs, 0);
          VS0 + 1:      chk("vs_last_sync_line", vs, 0);
          VS0 + 2:      chk("vs_line_after_sync", vs, 1);
          VT - 1:       chk("blank_last_line", blank, 0);
          default: ;
        endcase
      end
      if ((mx == HT - 1) && (my == VT - 1)) begin
        chk("frame_tick_at_end", frame_tick, 1);
        chk("line_tick_with_frame_tick", line_tick, 1);
      end
      if ((mx == 0) && (my == 0) && (i > 0))
        chk("frame_count_at_wrap", frame_count, n_ft);
      if (i == 0) chk("blank_d_rel_cycle0", blank_d, 0);
      if (i == 1) chk("blank_d_rel_cycle1", blank_d, 0);
      if (i == 2) chk("blank_d_rel_cycle2", blank_d, 1);

      h2 = h1;
      h1 = {exp_b, exp_h, exp_v};
      if (mx == HT - 1) begin
        mx = 0;
        if (my == VT - 1) begin
          my = 0;
          fc++;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
      tick();
    end

    chk("coord_mismatch_cycles",   bad_xy,    0);
    chk("sync_mismatch_cycles",    bad_sync,  0);
    chk("delay_mismatch_cycles",   bad_d,     0);
    chk("tick_count_mismatch",     bad_tick,  0);
    chk("line_ticks_first_frame",  lt_frame1, VT);
    chk("line_ticks_two_frames",   n_lt,      2 * VT);
    chk("frame_ticks_two_frames",  n_ft,      2);
    chk("frame_period_cycles",     period,    FRAME);

    // Reset for one cycle at pixel 700 of the second vsync line.
    w = 0;
    while (!((DrawX == 10'd700) && (int'(DrawY) == VS0 + 1)) && (w < FRAME)) begin
      tick();
      w++;
    end
    chk("reached_x700_vsync", (w < FRAME), 1);
    chk("vs_before_reset", vs, 0);
    chk("hs_before_reset", hs, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_DrawX",       DrawX,       0);
    chk("midrst_DrawY",       DrawY,       0);
    chk("midrst_hs",          hs,          1);
    chk("midrst_vs",          vs,          1);
    chk("midrst_blank",       blank,       1);
    chk("midrst_frame_count", frame_count, 0);
    chk("midrst_frame_tick",  frame_tick,  0);
    chk("midrst_blank_d",     blank_d,     0);
    chk("midrst_vs_d",        vs_d,        1);
    tick();
    chk("resume_DrawX",      DrawX,      1);
    chk("resume_DrawY",      DrawY,      0);
    chk("resume_frame_tick", frame_tick, 0);
    chk("resume_blank_d",    blank_d,    0);
    tick();
    chk("resume_blank_d_2",  blank_d,    1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
